// File: rtl/streamer_csr_pkg.sv
// Shared types for the CSR table sequencer: FSM states, CSR width and table entry layout.
package streamer_csr_pkg;

  localparam int unsigned CsrWidth = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_READ     = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_LAUNCH   = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic [CsrWidth-1:0] addr;
    logic [CsrWidth-1:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/streamer_csr_sequencer_if.sv
// CSR request/response bus between the sequencer (master) and a CSR target (slave).
interface streamer_csr_sequencer_if;
  import streamer_csr_pkg::*;

  logic [CsrWidth-1:0] req_addr;
  logic [CsrWidth-1:0] req_data;
  logic                req_write;
  logic                req_valid;
  logic                req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [CsrWidth-1:0] rsp_data;

  modport master (
    output req_addr, req_data, req_write, req_valid, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_addr, req_data, req_write, req_valid, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/streamer_csr_sequencer_table.sv
// Config table: register array with one write port and one combinational read port.
module csr_cfg_table
  import streamer_csr_pkg::*;
#(
  parameter  int unsigned NumEntries = 16,
  localparam int unsigned IdxW       = $clog2(NumEntries)
) (
  input  logic            clk_i,
  input  logic            i_wr_en,
  input  logic [IdxW-1:0] i_wr_idx,
  input  cfg_entry_t      i_wr_entry,
  input  logic [IdxW-1:0] i_rd_idx,
  output cfg_entry_t      o_rd_entry
);

  cfg_entry_t r_mem [NumEntries];

  // Contents survive reset; only the entry count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_entry;
    end
  end

  assign o_rd_entry = r_mem[i_rd_idx];

endmodule

// File: rtl/streamer_csr_sequencer.sv
// Replays a host-programmed table of CSR writes, optionally reads each entry back
// to verify it, then writes the launch register and pulses done.
module streamer_csr_sequencer
  import streamer_csr_pkg::*;
#(
  parameter  int unsigned         NumEntries     = 16,
  parameter  bit                  VerifyReadback = 1'b1,
  parameter  logic [CsrWidth-1:0] LaunchAddr     = 32'd13,
  localparam int unsigned         IdxW           = $clog2(NumEntries),
  localparam int unsigned         CntW           = IdxW + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_wr_valid_i,
  output logic                cfg_wr_ready_o,
  input  logic [CsrWidth-1:0] cfg_wr_addr_i,
  input  logic [CsrWidth-1:0] cfg_wr_data_i,
  input  logic                start_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                mismatch_o,
  output logic [IdxW-1:0]     mismatch_idx_o,
  output logic [CsrWidth-1:0] io_csr_req_bits_addr_o,
  output logic [CsrWidth-1:0] io_csr_req_bits_data_o,
  output logic                io_csr_req_bits_write_o,
  output logic                io_csr_req_valid_o,
  input  logic                io_csr_req_ready_i,
  input  logic                io_csr_rsp_valid_i,
  output logic                io_csr_rsp_ready_o,
  input  logic [CsrWidth-1:0] io_csr_rsp_bits_data_i
);

  seq_state_e      r_state;
  seq_state_e      w_state_next;
  logic [CntW-1:0] r_count;
  logic [IdxW-1:0] r_idx;
  logic            r_mismatch;
  logic [IdxW-1:0] r_mismatch_idx;
  cfg_entry_t      w_rd_entry;
  cfg_entry_t      w_wr_entry;
  logic            w_push;
  logic            w_last;
  logic            w_rsp_fire;
  logic            w_rsp_bad;

  // Clear beats a coinciding push, so a push is only taken when clear is low.
  assign cfg_wr_ready_o  = (r_state == ST_IDLE) && (r_count < CntW'(NumEntries));
  assign w_push          = cfg_wr_valid_i && cfg_wr_ready_o && !clear_i;
  assign w_last          = ({1'b0, r_idx} == (r_count - CntW'(1)));
  assign w_rsp_fire      = (r_state == ST_WAIT_RSP) && io_csr_rsp_valid_i;
  assign w_rsp_bad       = (io_csr_rsp_bits_data_i != w_rd_entry.data);
  assign w_wr_entry.addr = cfg_wr_addr_i;
  assign w_wr_entry.data = cfg_wr_data_i;
  assign mismatch_o      = r_mismatch;
  assign mismatch_idx_o  = r_mismatch_idx;

  csr_cfg_table #(.NumEntries(NumEntries)) u_table (
    .clk_i      (clk_i),
    .i_wr_en    (w_push),
    .i_wr_idx   (r_count[IdxW-1:0]),
    .i_wr_entry (w_wr_entry),
    .i_rd_idx   (r_idx),
    .o_rd_entry (w_rd_entry)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and bus outputs; request fields are a pure function of state and table.
  always_comb begin
    w_state_next            = r_state;
    io_csr_req_valid_o      = 1'b0;
    io_csr_req_bits_write_o = 1'b0;
    io_csr_req_bits_addr_o  = '0;
    io_csr_req_bits_data_o  = '0;
    io_csr_rsp_ready_o      = 1'b0;
    busy_o                  = (r_state != ST_IDLE);
    done_o                  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !clear_i) begin
          w_state_next = (r_count != CntW'(0)) ? ST_WRITE : ST_LAUNCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        io_csr_req_valid_o      = 1'b1;
        io_csr_req_bits_write_o = 1'b1;
        io_csr_req_bits_addr_o  = w_rd_entry.addr;
        io_csr_req_bits_data_o  = w_rd_entry.data;
        if (io_csr_req_ready_i && w_last) begin
          w_state_next = VerifyReadback ? ST_READ : ST_LAUNCH;
        end else begin
          w_state_next = ST_WRITE;
        end
      end
      ST_READ: begin
        io_csr_req_valid_o     = 1'b1;
        io_csr_req_bits_addr_o = w_rd_entry.addr;
        if (io_csr_req_ready_i) begin
          w_state_next = ST_WAIT_RSP;
        end else begin
          w_state_next = ST_READ;
        end
      end
      ST_WAIT_RSP: begin
        io_csr_rsp_ready_o = 1'b1;
        if (w_rsp_fire) begin
          w_state_next = w_last ? ST_LAUNCH : ST_READ;
        end else begin
          w_state_next = ST_WAIT_RSP;
        end
      end
      ST_LAUNCH: begin
        io_csr_req_valid_o      = 1'b1;
        io_csr_req_bits_write_o = 1'b1;
        io_csr_req_bits_addr_o  = LaunchAddr;
        io_csr_req_bits_data_o  = CsrWidth'(1);
        if (io_csr_req_ready_i) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_LAUNCH;
        end
      end
      ST_DONE: begin
        done_o       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Table count, walk index and sticky mismatch capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count        <= '0;
      r_idx          <= '0;
      r_mismatch     <= 1'b0;
      r_mismatch_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear_i) begin
            r_count        <= '0;
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= '0;
          end else begin
            if (w_push) begin
              r_count <= r_count + CntW'(1);
            end
            if (start_i) begin
              r_idx          <= '0;
              r_mismatch     <= 1'b0;
              r_mismatch_idx <= '0;
            end
          end
        end
        ST_WRITE: begin
          if (io_csr_req_ready_i) begin
            r_idx <= w_last ? '0 : r_idx + IdxW'(1);
          end
        end
        ST_WAIT_RSP: begin
          if (w_rsp_fire) begin
            if (w_rsp_bad && !r_mismatch) begin
              r_mismatch     <= 1'b1;
              r_mismatch_idx <= r_idx;
            end
            r_idx <= w_last ? '0 : r_idx + IdxW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_streamer_csr_sequencer.sv
// Randomized bench: acts as CSR target and checks every run against a transaction-list model.
module tb_streamer_csr_sequencer;
  import streamer_csr_pkg::*;

  localparam int N  = 16;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic          clk;
  logic          rst;
  logic          cfg_wr_valid;
  logic          cfg_wr_ready;
  logic [31:0]   cfg_wr_addr;
  logic [31:0]   cfg_wr_data;
  logic          start;
  logic          clr;
  logic          busy;
  logic          done;
  logic          mismatch;
  logic [IW-1:0] mismatch_idx;

  streamer_csr_sequencer_if csr_bus();

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_addr[$];
  logic [31:0] m_data[$];
  logic [31:0] rsp_xor[N];

  streamer_csr_sequencer #(.NumEntries(N), .VerifyReadback(1'b1), .LaunchAddr(32'd13)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .cfg_wr_valid_i          (cfg_wr_valid),
    .cfg_wr_ready_o          (cfg_wr_ready),
    .cfg_wr_addr_i           (cfg_wr_addr),
    .cfg_wr_data_i           (cfg_wr_data),
    .start_i                 (start),
    .clear_i                 (clr),
    .busy_o                  (busy),
    .done_o                  (done),
    .mismatch_o              (mismatch),
    .mismatch_idx_o          (mismatch_idx),
    .io_csr_req_bits_addr_o  (csr_bus.req_addr),
    .io_csr_req_bits_data_o  (csr_bus.req_data),
    .io_csr_req_bits_write_o (csr_bus.req_write),
    .io_csr_req_valid_o      (csr_bus.req_valid),
    .io_csr_req_ready_i      (csr_bus.req_ready),
    .io_csr_rsp_valid_i      (csr_bus.rsp_valid),
    .io_csr_rsp_ready_o      (csr_bus.rsp_ready),
    .io_csr_rsp_bits_data_i  (csr_bus.rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_addr.delete();
    m_data.delete();
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    logic exp_rdy;
    exp_rdy = (m_addr.size() < N);
    n_cmp++;
    if (cfg_wr_ready !== exp_rdy) begin
      n_bad++;
      $display("FAIL push_ready: got %b expected %b (entries %0d)", cfg_wr_ready, exp_rdy, m_addr.size());
    end
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = a;
    cfg_wr_data  = d;
    @(negedge clk);
    cfg_wr_valid = 1'b0;
    if (exp_rdy) begin
      m_addr.push_back(a);
      m_data.push_back(d);
    end
  endtask

  task automatic push_directed();
    do_clear();
    push(32'd0, 32'd10);
    push(32'd1, 32'd1);
    push(32'd9, 32'd0);
    push(32'd10, 32'd8);
  endtask

  // One full run as CSR target; expectations come from the table model and rsp_xor.
  task automatic run_seq(input int ready_pct, input int stall_first, input string tag);
    txn_t exp_q[$];
    txn_t obs_q[$];
    int   hs_cyc[$];
    txn_t t;
    txn_t prev;
    logic prev_stall;
    logic exp_mm;
    int   exp_mm_idx;
    int   n;
    int   rd_k;
    int   stall_left;
    int   stalls_seen;
    int   done_cyc;
    int   k;
    n = m_addr.size();
    for (int i = 0; i < n; i++) exp_q.push_back('{wr: 1'b1, addr: m_addr[i], data: m_data[i]});
    for (int i = 0; i < n; i++) exp_q.push_back('{wr: 1'b0, addr: m_addr[i], data: 32'd0});
    exp_q.push_back('{wr: 1'b1, addr: 32'd13, data: 32'd1});
    exp_mm     = 1'b0;
    exp_mm_idx = 0;
    for (int i = 0; i < n; i++) begin
      if (rsp_xor[i] != 32'd0 && !exp_mm) begin
        exp_mm     = 1'b1;
        exp_mm_idx = i;
      end
    end
    rd_k        = 0;
    stall_left  = stall_first;
    stalls_seen = 0;
    prev_stall  = 1'b0;
    prev        = '0;
    done_cyc    = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
      if (prev_stall) begin
        t = '{wr: csr_bus.req_write, addr: csr_bus.req_addr, data: csr_bus.req_data};
        n_cmp++;
        if (csr_bus.req_valid !== 1'b1 || t !== prev) begin
          n_bad++;
          $display("FAIL %s_stable: got valid %b txn %h expected valid 1 txn %h", tag, csr_bus.req_valid, t, prev);
        end
      end
      if (done === 1'b1) done_cyc = cyc;
      if (stall_left > 0) begin
        csr_bus.req_ready = 1'b0;
        stall_left--;
      end else begin
        csr_bus.req_ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (csr_bus.rsp_ready === 1'b1) begin
        k = (rd_k > 0) ? rd_k - 1 : 0;
        csr_bus.rsp_valid = (ready_pct == 100) ? 1'b1 : 1'($urandom_range(0, 1));
        csr_bus.rsp_data  = (k < n) ? (m_data[k] ^ rsp_xor[k]) : 32'd0;
      end else begin
        csr_bus.rsp_valid = 1'($urandom_range(0, 1));
        csr_bus.rsp_data  = $urandom;
      end
      t = '{wr: csr_bus.req_write, addr: csr_bus.req_addr, data: csr_bus.req_data};
      if (csr_bus.req_valid === 1'b1 && csr_bus.req_ready) begin
        obs_q.push_back(t);
        hs_cyc.push_back(cyc);
        if (!t.wr) rd_k++;
      end
      prev_stall = (csr_bus.req_valid === 1'b1) && !csr_bus.req_ready;
      if (prev_stall) stalls_seen++;
      prev = t;
      @(negedge clk);
    end
    csr_bus.req_ready = 1'b0;
    csr_bus.rsp_valid = 1'b0;
    n_cmp++;
    if (done_cyc < 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got no done pulse expected one within budget", tag);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_txn_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s_txn[%0d]: got %h expected %h", tag, i, obs_q[i], exp_q[i]);
      end
    end
    if (hs_cyc.size() > 0 && done_cyc >= 0) begin
      n_cmp++;
      if (done_cyc != hs_cyc[hs_cyc.size()-1] + 1) begin
        n_bad++;
        $display("FAIL %s_done_latency: got cycle %0d expected %0d", tag, done_cyc, hs_cyc[hs_cyc.size()-1] + 1);
      end
    end
    if (ready_pct == 100) begin
      n_cmp++;
      if (stalls_seen != stall_first) begin
        n_bad++;
        $display("FAIL %s_stall_cycles: got %0d expected %0d", tag, stalls_seen, stall_first);
      end
      if (stall_first == 0 && n > 0 && hs_cyc.size() >= n) begin
        n_cmp++;
        if (hs_cyc[n-1] - hs_cyc[0] != n - 1) begin
          n_bad++;
          $display("FAIL %s_write_gap: got span %0d expected %0d", tag, hs_cyc[n-1] - hs_cyc[0], n - 1);
        end
      end
    end
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s_after_done: got done,busy %b expected 00", tag, {done, busy});
    end
    n_cmp++;
    if (mismatch !== exp_mm) begin
      n_bad++;
      $display("FAIL %s_mismatch: got %b expected %b", tag, mismatch, exp_mm);
    end
    if (exp_mm) begin
      n_cmp++;
      if (mismatch_idx !== IW'(exp_mm_idx)) begin
        n_bad++;
        $display("FAIL %s_mismatch_idx: got %0d expected %0d", tag, mismatch_idx, exp_mm_idx);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, csr_bus.req_valid, csr_bus.rsp_ready, mismatch, cfg_wr_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 000001", {busy, done, csr_bus.req_valid, csr_bus.rsp_ready, mismatch, cfg_wr_ready});
    end
    n_cmp++;
    if ({csr_bus.req_addr, csr_bus.req_data, csr_bus.req_write, mismatch_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: got addr %h data %h write %b idx %0d expected zeros", csr_bus.req_addr, csr_bus.req_data, csr_bus.req_write, mismatch_idx);
    end
  endtask

  task automatic test_echo();
    push_directed();
    for (int i = 0; i < N; i++) rsp_xor[i] = 32'd0;
    run_seq(100, 0, "echo");
  endtask

  task automatic test_mismatch();
    for (int i = 0; i < N; i++) rsp_xor[i] = 32'd0;
    rsp_xor[2] = 32'd5;
    run_seq(100, 0, "mismatch");
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++) rsp_xor[i] = 32'd0;
    run_seq(100, 3, "stall");
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 17; i++) push($urandom, $urandom);
    n_cmp++;
    if (cfg_wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL full_ready: got %b expected 0", cfg_wr_ready);
    end
    do_clear();
    run_seq(100, 0, "empty");
  endtask

  task automatic test_clear_push();
    push_directed();
    clr          = 1'b1;
    cfg_wr_valid = 1'b1;
    cfg_wr_addr  = 32'h55;
    cfg_wr_data  = 32'h66;
    @(negedge clk);
    clr          = 1'b0;
    cfg_wr_valid = 1'b0;
    m_addr.delete();
    m_data.delete();
    run_seq(100, 0, "clear_push");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n;
      do_clear();
      n = int'($urandom_range(1, N));
      for (int i = 0; i < n; i++) push($urandom, $urandom);
      for (int i = 0; i < N; i++) rsp_xor[i] = ($urandom_range(0, 3) == 0) ? ($urandom | 32'd1) : 32'd0;
      run_seq(int'($urandom_range(30, 100)), 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) rsp_xor[i] = 32'd0;
    rsp_xor[0] = 32'h8000_0000;
    run_seq(100, 0, "rerun_bad");
    for (int i = 0; i < N; i++) rsp_xor[i] = 32'd0;
    run_seq(int'($urandom_range(40, 100)), 0, "rerun_good");
  endtask

  task automatic test_reset_mid();
    logic hit;
    push_directed();
    for (int i = 0; i < N; i++) rsp_xor[i] = 32'd0;
    hit   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    csr_bus.req_ready = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (csr_bus.rsp_ready === 1'b1) hit = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL midreset_reach: got no response phase expected one within budget");
    end
    rst               = 1'b1;
    csr_bus.rsp_valid = 1'b1;
    csr_bus.rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    m_addr.delete();
    m_data.delete();
    n_cmp++;
    if ({busy, done, csr_bus.req_valid, csr_bus.rsp_ready, mismatch, cfg_wr_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL midreset_flags: got %b expected 000001", {busy, done, csr_bus.req_valid, csr_bus.rsp_ready, mismatch, cfg_wr_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, mismatch} !== 2'b00) begin
      n_bad++;
      $display("FAIL midreset_stray: got busy,mismatch %b expected 00", {busy, mismatch});
    end
    csr_bus.rsp_valid = 1'b0;
    csr_bus.req_ready = 1'b0;
    run_seq(100, 0, "post_reset");
  endtask

  initial begin
    rst               = 1'b1;
    cfg_wr_valid      = 1'b0;
    cfg_wr_addr       = 32'd0;
    cfg_wr_data       = 32'd0;
    start             = 1'b0;
    clr               = 1'b0;
    csr_bus.req_ready = 1'b0;
    csr_bus.rsp_valid = 1'b0;
    csr_bus.rsp_data  = 32'd0;
    for (int i = 0; i < N; i++) rsp_xor[i] = 32'd0;
    test_reset();
    test_echo();
    test_mismatch();
    test_stall();
    test_overflow();
    test_clear_push();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/streamer_csr_sequencer.md
STREAMER_CSR_SEQUENCER -- requirements
Module: streamer_csr_sequencer

Interface
REQ-001 SHALL have parameter NumEntries, default 16, meaning depth of the config table (power of two, at least 2).
REQ-002 SHALL have parameter VerifyReadback, default 1, meaning readback-compare phase enabled (0 skips it).
REQ-003 SHALL have parameter LaunchAddr, default 13, meaning CSR address written with data 1 to start the streamer.
REQ-004 SHALL have ports:
- clk_i  in  1  sole clock; one clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- cfg_wr_valid_i  in  1  host table-push valid.
- cfg_wr_ready_o  out  1  host table-push ready.
- cfg_wr_addr_i  in  32  CSR address to program.
- cfg_wr_data_i  in  32  CSR data to program.
- start_i  in  1  run request, single-cycle pulse.
- clear_i  in  1  empty the table and clear mismatch state.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at end of run.
- mismatch_o  out  1  sticky readback mismatch.
- mismatch_idx_o  out  $clog2(NumEntries)  index of first mismatching entry.
- io_csr_req_bits_addr_o  out  32  CSR request address.
- io_csr_req_bits_data_o  out  32  CSR request data.
- io_csr_req_bits_write_o  out  1  CSR request is a write.
- io_csr_req_valid_o  out  1  CSR request valid.
- io_csr_req_ready_i  in  1  CSR request ready.
- io_csr_rsp_valid_i  in  1  CSR response valid (reads only).
- io_csr_rsp_ready_o  out  1  CSR response ready.
- io_csr_rsp_bits_data_i  in  32  CSR read data.

Function
REQ-005 SHALL store (addr,data) pairs in a table indexed 0..count-1; a push is accepted on a cycle with cfg_wr_valid_i and cfg_wr_ready_o, and increments count.
REQ-006 SHALL drive cfg_wr_ready_o = (state==IDLE) and (count<NumEntries); a push offered when full is not accepted and count does not wrap.
REQ-007 SHALL implement FSM states IDLE, WRITE, READ, WAIT_RSP, LAUNCH, DONE.
REQ-008 IDLE: on start_i, SHALL clear the index and go to WRITE if count>0, else go to LAUNCH; start_i in any other state SHALL be ignored.
REQ-009 WRITE: SHALL hold valid=1, write=1, addr/data=table[idx] stable until io_csr_req_ready_i; on that handshake SHALL advance idx; after the last entry SHALL go to READ (idx reset to 0) if VerifyReadback, else to LAUNCH.
REQ-010 READ: SHALL present valid=1, write=0, addr=table[idx], data=0 until ready, then go to WAIT_RSP.
REQ-011 WAIT_RSP: SHALL drive io_csr_rsp_ready_o=1 (0 in all other states); on rsp valid SHALL compare data to table[idx]; on first mismatch of a run SHALL set mismatch_o and capture idx; SHALL then go to READ (next idx) or, after the last entry, to LAUNCH.
REQ-012 Responses arriving outside WAIT_RSP SHALL be ignored; writes SHALL NOT expect responses.
REQ-013 LAUNCH: SHALL issue write addr=LaunchAddr, data=1 until ready, then go to DONE.
REQ-014 DONE: SHALL assert done_o for exactly one cycle, then return to IDLE; the table is retained for reruns.
REQ-015 busy_o SHALL equal (state != IDLE); io_csr_req_valid_o SHALL be 1 only in WRITE, READ, LAUNCH.
REQ-016 With back-to-back ready, the request-to-request gap SHALL be 0 cycles in WRITE, and done_o SHALL fire 1 cycle after the LAUNCH handshake.
REQ-017 clear_i SHALL act only in IDLE: count:=0, mismatch_o:=0, mismatch_idx_o:=0; if clear_i and a push coincide, clear SHALL win.
REQ-018 mismatch_o SHALL be cleared at start of each run, then stay sticky until the next start_i, clear_i or reset.

Reset
REQ-019 rst_i SHALL, at any state including mid-handshake, force IDLE, count=0, idx=0, and all outputs to 0 except cfg_wr_ready_o=1 on the following cycle; table contents need not be reset.

Structure
REQ-020 SHALL place the state enum, the CSR width constant (32) and the table-entry struct in a shared package, streamer_csr_pkg.
REQ-021 The table MAY be a single sub-module, csr_cfg_table (register array with write port and one combinational read port).

Verification
REQ-022 Push (0,10),(1,1),(9,0),(10,8), start, ready always 1, reads echo -> 4 writes, 4 reads, write (13,1); done_o pulse; mismatch_o=0.
REQ-023 Same table, read of entry 2 returns 5 -> mismatch_o=1, mismatch_idx_o=2; LAUNCH still issued.
REQ-024 ready held low 3 cycles on first write -> addr/data/valid stable for those cycles; no entry skipped.
REQ-025 Push 17 entries with NumEntries=16 -> 16 accepted; cfg_wr_ready_o=0 after 16; start with count=0 after clear_i -> only the (13,1) write, then done_o.
REQ-026 Assert rst_i during WAIT_RSP -> next cycle IDLE, busy_o=0, valid=0, count=0; a stray rsp_valid is ignored.
